// File: rtl/garage_door_ctrl_gen2.sv
// Gen2 single-door garage controller: Activate edge detect, limit debounce, stop/reverse, run timeout.
// Optional feature macro OBSTRUCT_REVERSE_EN: Obstruct while closing reverses the door.

module garage_door_ctrl_gen2 #(
  parameter int DEBOUNCE_CYC = 2,
  parameter int TIMEOUT_CYC  = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic Activate,
  input  logic Up_Max,
  input  logic DN_Max,
  input  logic Obstruct,
  input  logic Clr_Fault,
  output logic UP_M,
  output logic DN_M,
  output logic Fault
);

  typedef enum logic [2:0] {IDLE, MV_UP, MV_DN, HOLD, FAULT} state_t;

`ifdef OBSTRUCT_REVERSE_EN
  localparam bit OBS_EN = 1'b1;
`else
  localparam bit OBS_EN = 1'b0;
`endif

  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t        state, state_nxt;
  logic          act_q, act_pulse, dir_up;
  logic [TW-1:0] timer;
  logic [1:0]    lim_raw, lim_db;
  logic          up_db, dn_db, conflict, timeout_hit, moving_nxt, entering;

  // act_q resets high so a button already held at reset release is not a press.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) act_q <= 1'b1;
    else      act_q <= Activate;
  end

  assign act_pulse = Activate & ~act_q;

  assign lim_raw = {DN_Max, Up_Max};
  assign up_db   = lim_db[0];
  assign dn_db   = lim_db[1];

  generate
    if (DEBOUNCE_CYC == 0) begin : g_db_bypass
      assign lim_db = lim_raw;
    end else begin : g_db
      localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
      localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYC - 1);
      logic [DW-1:0] cnt [2];

      // Count consecutive disagreeing samples; any agreeing sample restarts the count.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < 2; i++) begin
            cnt[i]    <= '0;
            lim_db[i] <= 1'b0;
          end
        end else begin
          for (int i = 0; i < 2; i++) begin
            if (lim_raw[i] == lim_db[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              cnt[i]    <= '0;
              lim_db[i] <= lim_raw[i];
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  assign conflict    = up_db & dn_db;
  assign timeout_hit = (TIMEOUT_CYC > 0) && (timer == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (conflict)       state_nxt = FAULT;
        else if (act_pulse) state_nxt = dn_db ? MV_UP : MV_DN;
      end
      MV_UP: begin
        if (conflict)         state_nxt = FAULT;
        else if (up_db)       state_nxt = IDLE;
        else if (act_pulse)   state_nxt = HOLD;
        else if (timeout_hit) state_nxt = FAULT;
      end
      MV_DN: begin
        if (conflict)                 state_nxt = FAULT;
        else if (dn_db)               state_nxt = IDLE;
        else if (OBS_EN && Obstruct)  state_nxt = MV_UP;
        else if (act_pulse)           state_nxt = HOLD;
        else if (timeout_hit)         state_nxt = FAULT;
      end
      HOLD: begin
        if (act_pulse)     state_nxt = dir_up ? MV_DN : MV_UP;
        else if (conflict) state_nxt = FAULT;
      end
      FAULT: begin
        if (Clr_Fault) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A move "entry" includes the direct MV_DN -> MV_UP obstruct reversal.
  assign moving_nxt = (state_nxt == MV_UP) || (state_nxt == MV_DN);
  assign entering   = moving_nxt && (state_nxt != state);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer  <= '0;
      dir_up <= 1'b0;
    end else begin
      if (!moving_nxt || entering) timer <= '0;
      else if (timer != '1)        timer <= timer + 1'b1;
      if (entering) dir_up <= (state_nxt == MV_UP);
    end
  end

  assign UP_M  = (state == MV_UP);
  assign DN_M  = (state == MV_DN);
  assign Fault = (state == FAULT);

endmodule
